axi_lite_csr_bridge: RTL and testbench
======================================

Name: axi_lite_csr_bridge

Overview:
AXI4-Lite slave front-end that drives the CSR register file's simple strobe interface (reg_addr/reg_wdata/reg_write/reg_read) and turns its reg_rdata and 2-bit access_violation code into AXI responses. It sits directly upstream of the register file, between the system interconnect and the CSR array. One transaction is outstanding at a time. Simultaneous pending read and write requests are arbitrated round-robin.

Parameters:
AXI_AW, 8, AXI byte-address width; must be >= REG_AW+2
REG_DW, 32, data width; equals AXI data width and register-file width
REG_AW, 4, register-file word-address width

Ports:
clk  in  1  clock
srst  in  1  reset; synchronous, active-high
s_awaddr  in  AXI_AW  write address
s_awvalid / s_awready  in / out  1  AW handshake
s_wdata  in  REG_DW  write data
s_wstrb  in  REG_DW/8  write strobes
s_wvalid / s_wready  in / out  1  W handshake
s_bresp  out  2  write response
s_bvalid / s_bready  out / in  1  B handshake
s_araddr  in  AXI_AW  read address
s_arvalid / s_arready  in / out  1  AR handshake
s_rdata  out  REG_DW  read data
s_rresp  out  2  read response
s_rvalid / s_rready  out / in  1  R handshake
reg_addr  out  REG_AW  register word address
reg_wdata  out  REG_DW  register write data
reg_write  out  1  write strobe; single-cycle
reg_read  out  1  read strobe; single-cycle
reg_rdata  in  REG_DW  register read data; valid the cycle after reg_read
access_violation  in  2  0 = none, 1 = write violation, 2 = read violation, 3 = address out of range; valid the cycle after a strobe

Behaviour:
- Reset (srst=1 at a clk edge): state IDLE; all holding flags clear; last_grant = READ. All ready, valid and strobe outputs 0. s_bresp, s_rresp, s_rdata, reg_addr and reg_wdata are 0.
- Holding registers: aw_held, w_held and ar_held are independent.
  - s_awready = !aw_held, s_wready = !w_held, s_arready = !ar_held, in any state.
  - A handshake latches the address or data/strobe and sets the flag.
  - AW and W may arrive in either order or in the same cycle.
- Grant, evaluated only in IDLE:
  - wr_req = aw_held & w_held; rd_req = ar_held.
  - If only one is requesting, grant it.
  - If both are requesting, grant the opposite of last_grant.
  - The granted op's flags are cleared as the FSM leaves IDLE; last_grant is updated.
- Pre-checks at grant:
  - decode_err = any of addr[AXI_AW-1:REG_AW+2] nonzero.
  - For writes, strb_err = s_wstrb held value != all-ones.
  - addr[1:0] is ignored.
  - If either check fails, no strobe is issued. The FSM goes straight to the response state: DECERR (2'b11) for decode_err, otherwise SLVERR (2'b10).
- FSM:
  - IDLE -> EXEC on a clean grant. In EXEC, exactly one of reg_write/reg_read is 1 for one cycle, with reg_addr = addr[REG_AW+1:2] and reg_wdata = held data.
  - EXEC -> SAMPLE. In SAMPLE, capture reg_rdata (reads only) and access_violation.
  - Response mapping: 0 -> OKAY (00); 1 or 2 -> SLVERR (10); 3 -> DECERR (11).
  - SAMPLE -> BRESP or RRESP.
  - BRESP: s_bvalid=1 until s_bready; then IDLE. RRESP: s_rvalid=1 until s_rready; then IDLE.
  - s_rdata is 0 on any non-OKAY read. s_bresp, s_rresp and s_rdata are stable while valid is high.
- Latency: with the AR handshake at cycle 0 and the bridge idle:
  - ar_held is set in cycle 1;
  - reg_read = 1 in cycle 2;
  - s_rvalid rises in cycle 3+1 = 4.
  - Writes are the same, counted from the later of the AW and W handshakes.
- Back-to-back: a new request already held is granted in the IDLE cycle directly after the response completes.
- Strobes are never asserted outside EXEC; reg_write and reg_read are never both 1.
- srst mid-transaction: the transaction is abandoned with no response; all held requests are dropped. A strobe in progress deasserts the next cycle.

Test Plan:
- Write: AW and W same cycle, awaddr=0x08, wdata=0xDEADBEEF, wstrb=0xF -> reg_write pulses once with reg_addr=2 and reg_wdata=0xDEADBEEF; bresp=00.
- Read: araddr=0x08, regfile returns 0xDEADBEEF with violation 0 -> reg_read is seen in cycle 2; rvalid rises in cycle 4; rdata=0xDEADBEEF, rresp=00.
- Violations: write with violation=1 -> bresp=10; read with violation=2 -> rresp=10, rdata=0; violation=3 -> DECERR.
- Pre-check errors:
  - awaddr=0x40 (REG_AW=4, AXI_AW=8) -> no reg_write; bresp=11.
  - wstrb=0x3 -> no reg_write; bresp=10.
- Arbitration: W arrives 3 cycles before AW; AR and the completed write pair pending together in IDLE after reset -> write granted first (last_grant=READ), then read. Hold bready=0 and rready=0 for 5 cycles -> valid, resp and data stay stable.
- Reset: assert srst in the EXEC cycle of a read -> no rvalid ever; all readies return to 1; the next read completes normally.

Source files
------------

// File: rtl/axi_lite_csr_bridge_if.sv
// axi_lite_csr_bridge_if: AXI4-Lite bus bundle between the interconnect (master)
// and the CSR bridge (slave).
interface axi_lite_csr_bridge_if #(
   parameter int AXI_AW = 8,
   parameter int REG_DW = 32
);
   logic [AXI_AW-1:0]   awaddr;
   logic                awvalid;
   logic                awready;
   logic [REG_DW-1:0]   wdata;
   logic [REG_DW/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   logic [AXI_AW-1:0]   araddr;
   logic                arvalid;
   logic                arready;
   logic [REG_DW-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;
   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi_lite_csr_bridge.sv
// axi_lite_csr_bridge: AXI4-Lite slave driving a CSR register file strobe interface,
// one transaction at a time with round-robin read/write arbitration.
module axi_lite_csr_bridge #(
   parameter int AXI_AW = 8,
   parameter int REG_DW = 32,
   parameter int REG_AW = 4
) (
   input  logic                 clk,
   input  logic                 srst,
   axi_lite_csr_bridge_if.slave s,
   output logic [REG_AW-1:0]    reg_addr,
   output logic [REG_DW-1:0]    reg_wdata,
   output logic                 reg_write,
   output logic                 reg_read,
   input  logic [REG_DW-1:0]    reg_rdata,
   input  logic [1:0]           access_violation
);
   localparam logic [2:0] IDLE = 3'd0, EXEC = 3'd1, SAMPLE = 3'd2, BRESP = 3'd3, RRESP = 3'd4;
   localparam int HW = AXI_AW - 2;
   logic [2:0]          state;
   logic                aw_held, w_held, ar_held, last_wr, cur_wr;
   logic [HW-1:0]       aw_addr, ar_addr, g_addr;
   logic [REG_DW-1:0]   w_data, rdata;
   logic [REG_DW/8-1:0] w_strb;
   logic [1:0]          resp;
   logic                wr_req, rd_req, gnt_wr, dec_err, pre_err;
   // addresses are held as word addresses; byte offset bits are dropped at capture
   always_comb begin
      wr_req  = aw_held & w_held;
      rd_req  = ar_held;
      gnt_wr  = wr_req & (!rd_req | !last_wr);
      g_addr  = gnt_wr ? aw_addr : ar_addr;
      dec_err = (g_addr >> REG_AW) != '0;
      pre_err = dec_err | (gnt_wr & (w_strb != '1));
   end
   assign s.awready = !aw_held;
   assign s.wready  = !w_held;
   assign s.arready = !ar_held;
   assign s.bvalid  = state == BRESP;
   assign s.rvalid  = state == RRESP;
   assign s.bresp   = resp;
   assign s.rresp   = resp;
   assign s.rdata   = rdata;
   assign reg_write = state == EXEC && cur_wr;
   assign reg_read  = state == EXEC && !cur_wr;
   always_ff @(posedge clk) begin
      if (srst) begin
         state     <= IDLE;
         aw_held   <= 1'b0;
         w_held    <= 1'b0;
         ar_held   <= 1'b0;
         last_wr   <= 1'b0;
         cur_wr    <= 1'b0;
         aw_addr   <= '0;
         ar_addr   <= '0;
         w_data    <= '0;
         w_strb    <= '0;
         resp      <= 2'b00;
         rdata     <= '0;
         reg_addr  <= '0;
         reg_wdata <= '0;
      end else begin
         if (s.awvalid && !aw_held) begin
            aw_held <= 1'b1;
            aw_addr <= s.awaddr[AXI_AW-1:2];
         end
         if (s.wvalid && !w_held) begin
            w_held <= 1'b1;
            w_data <= s.wdata;
            w_strb <= s.wstrb;
         end
         if (s.arvalid && !ar_held) begin
            ar_held <= 1'b1;
            ar_addr <= s.araddr[AXI_AW-1:2];
         end
         case (state)
            IDLE: if (wr_req || rd_req) begin
               cur_wr    <= gnt_wr;
               last_wr   <= gnt_wr;
               reg_addr  <= g_addr[REG_AW-1:0];
               reg_wdata <= w_data;
               resp      <= dec_err ? 2'b11 : 2'b10;
               state     <= pre_err ? (gnt_wr ? BRESP : RRESP) : EXEC;
               if (gnt_wr) begin
                  aw_held <= 1'b0;
                  w_held  <= 1'b0;
               end else begin
                  ar_held <= 1'b0;
                  rdata   <= '0;
               end
            end
            EXEC: state <= SAMPLE;
            SAMPLE: begin
               resp  <= access_violation == 2'd3 ? 2'b11 : access_violation != 2'd0 ? 2'b10 : 2'b00;
               state <= cur_wr ? BRESP : RRESP;
               if (!cur_wr) rdata <= access_violation == 2'd0 ? reg_rdata : '0;
            end
            BRESP: if (s.bready) state <= IDLE;
            RRESP: if (s.rready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_lite_csr_bridge.sv
// tb_axi_lite_csr_bridge: scoreboard bench for the AXI4-Lite CSR bridge with a
// behavioural register file model behind it.
module tb_axi_lite_csr_bridge;
   typedef struct {
      logic [1:0]  resp;
      logic [31:0] data;
   } exp_t;
   logic        clk = 1'b0;
   logic        srst = 1'b1;
   logic [3:0]  reg_addr;
   logic [31:0] reg_wdata;
   logic [31:0] reg_rdata = '0;
   logic        reg_write, reg_read;
   logic [1:0]  access_violation = 2'd0;
   logic [1:0]  viol = 2'd0;
   logic [31:0] mem [16];
   logic [31:0] exp_mem [16];
   logic [3:0]  last_waddr = '0, last_raddr = '0;
   logic [31:0] last_wdata = '0;
   exp_t        bq[$], rq[$];
   int          order[$];
   int          checks = 0, errors = 0, cyc = 0;
   int          wr_cnt = 0, rd_cnt = 0, both_cnt = 0, rd_cyc = 0;

   always #5 clk = ~clk;

   axi_lite_csr_bridge_if #(.AXI_AW(8), .REG_DW(32)) bus ();

   axi_lite_csr_bridge #(.AXI_AW(8), .REG_DW(32), .REG_AW(4)) dut (
      .clk(clk), .srst(srst), .s(bus),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_write(reg_write), .reg_read(reg_read),
      .reg_rdata(reg_rdata), .access_violation(access_violation)
   );

   // register file model: data and violation code valid the cycle after a strobe
   always @(posedge clk) begin
      cyc <= cyc + 1;
      access_violation <= (reg_write || reg_read) ? viol : 2'd0;
      if (reg_read) reg_rdata <= mem[reg_addr];
      if (reg_write && viol == 2'd0) mem[reg_addr] <= reg_wdata;
   end

   always @(negedge clk) begin
      if (reg_write) begin
         wr_cnt++;
         last_waddr = reg_addr;
         last_wdata = reg_wdata;
         order.push_back(1);
      end
      if (reg_read) begin
         rd_cnt++;
         rd_cyc = cyc;
         last_raddr = reg_addr;
         order.push_back(0);
      end
      if (reg_write && reg_read) both_cnt++;
   end

   task automatic wait_b(input string nm, input int hold);
      exp_t e;
      int n = 0;
      e = bq.pop_front();
      while (bus.bvalid !== 1'b1 && n < 30) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.bvalid !== 1'b1) begin
         errors++;
         $display("FAIL %s: bvalid timeout got=%b want=1", nm, bus.bvalid);
         return;
      end
      for (int i = 0; i <= hold; i++) begin
         checks++;
         if (bus.bvalid !== 1'b1 || bus.bresp !== e.resp) begin
            errors++;
            $display("FAIL %s: hold %0d bvalid=%b bresp=%b want bvalid=1 bresp=%b", nm, i, bus.bvalid, bus.bresp, e.resp);
         end
         if (i < hold) @(negedge clk);
      end
      bus.bready = 1'b1;
      @(posedge clk);
      #1 bus.bready = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.bvalid !== 1'b0) begin
         errors++;
         $display("FAIL %s: bvalid after accept got=%b want=0", nm, bus.bvalid);
      end
   endtask

   task automatic wait_r(input string nm, input int hold, output int rise);
      exp_t e;
      int n = 0;
      rise = -1;
      e = rq.pop_front();
      while (bus.rvalid !== 1'b1 && n < 30) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.rvalid !== 1'b1) begin
         errors++;
         $display("FAIL %s: rvalid timeout got=%b want=1", nm, bus.rvalid);
         return;
      end
      rise = cyc;
      for (int i = 0; i <= hold; i++) begin
         checks++;
         if (bus.rvalid !== 1'b1 || bus.rresp !== e.resp || bus.rdata !== e.data) begin
            errors++;
            $display("FAIL %s: hold %0d rvalid=%b rresp=%b rdata=%h want rvalid=1 rresp=%b rdata=%h",
                     nm, i, bus.rvalid, bus.rresp, bus.rdata, e.resp, e.data);
         end
         if (i < hold) @(negedge clk);
      end
      bus.rready = 1'b1;
      @(posedge clk);
      #1 bus.rready = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.rvalid !== 1'b0) begin
         errors++;
         $display("FAIL %s: rvalid after accept got=%b want=0", nm, bus.rvalid);
      end
   endtask

   task automatic wr_txn(input logic [7:0] a, input logic [31:0] d, input logic [3:0] st,
                         input logic [1:0] v, input logic [1:0] er, input bit stb, input string nm);
      exp_t e;
      int w0 = wr_cnt;
      viol = v;
      e.resp = er;
      e.data = '0;
      bq.push_back(e);
      @(negedge clk);
      bus.awaddr = a; bus.awvalid = 1'b1;
      bus.wdata = d; bus.wstrb = st; bus.wvalid = 1'b1;
      @(posedge clk);
      #1 bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      @(negedge clk);
      wait_b(nm, 0);
      checks++;
      if (wr_cnt - w0 !== int'(stb)) begin
         errors++;
         $display("FAIL %s: reg_write pulses got=%0d want=%0d", nm, wr_cnt - w0, stb);
      end
      if (stb) begin
         checks++;
         if (last_waddr !== a[5:2] || last_wdata !== d) begin
            errors++;
            $display("FAIL %s: reg_addr=%h reg_wdata=%h want %h %h", nm, last_waddr, last_wdata, a[5:2], d);
         end
      end
      if (er == 2'b00) exp_mem[a[5:2]] = d;
   endtask

   task automatic rd_txn(input logic [7:0] a, input logic [1:0] v, input logic [1:0] er,
                         input bit stb, input bit lat, input string nm);
      exp_t e;
      int r0 = rd_cnt;
      int c0, rise;
      viol = v;
      e.resp = er;
      e.data = er == 2'b00 ? exp_mem[a[5:2]] : 32'h0;
      rq.push_back(e);
      @(negedge clk);
      c0 = cyc;
      bus.araddr = a; bus.arvalid = 1'b1;
      @(posedge clk);
      #1 bus.arvalid = 1'b0;
      @(negedge clk);
      wait_r(nm, 0, rise);
      checks++;
      if (rd_cnt - r0 !== int'(stb)) begin
         errors++;
         $display("FAIL %s: reg_read pulses got=%0d want=%0d", nm, rd_cnt - r0, stb);
      end
      if (stb) begin
         checks++;
         if (last_raddr !== a[5:2]) begin
            errors++;
            $display("FAIL %s: reg_addr got=%h want=%h", nm, last_raddr, a[5:2]);
         end
      end
      if (lat) begin
         checks++;
         if (rd_cyc - c0 !== 2 || rise - c0 !== 4) begin
            errors++;
            $display("FAIL %s: latency reg_read=%0d rvalid=%0d want 2 and 4", nm, rd_cyc - c0, rise - c0);
         end
      end
   endtask

   task automatic test_reset;
      srst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_ready: got=%b want=111", {bus.awready, bus.wready, bus.arready});
         end
         checks++;
         if ({bus.bvalid, bus.rvalid, reg_write, reg_read} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_valid: got=%b want=0000", {bus.bvalid, bus.rvalid, reg_write, reg_read});
         end
         checks++;
         if ({bus.bresp, bus.rresp, bus.rdata, reg_addr, reg_wdata} !== 72'h0) begin
            errors++;
            $display("FAIL reset_data: bresp=%b rresp=%b rdata=%h reg_addr=%h reg_wdata=%h want all 0",
                     bus.bresp, bus.rresp, bus.rdata, reg_addr, reg_wdata);
         end
         srst = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_write;
      wr_txn(8'h08, 32'hDEADBEEF, 4'hF, 2'd0, 2'b00, 1'b1, "write_ok");
   endtask

   task automatic test_read;
      rd_txn(8'h08, 2'd0, 2'b00, 1'b1, 1'b1, "read_ok");
   endtask

   task automatic test_violations;
      wr_txn(8'h10, 32'h11112222, 4'hF, 2'd1, 2'b10, 1'b1, "wr_viol1");
      rd_txn(8'h14, 2'd2, 2'b10, 1'b1, 1'b0, "rd_viol2");
      rd_txn(8'h18, 2'd3, 2'b11, 1'b1, 1'b0, "rd_viol3");
      wr_txn(8'h1C, 32'h33334444, 4'hF, 2'd3, 2'b11, 1'b1, "wr_viol3");
      rd_txn(8'h10, 2'd0, 2'b00, 1'b1, 1'b1, "rd_after_viol");
   endtask

   task automatic test_precheck;
      wr_txn(8'h40, 32'hCAFEF00D, 4'hF, 2'd0, 2'b11, 1'b0, "wr_decerr");
      wr_txn(8'h04, 32'h0BADF00D, 4'h3, 2'd0, 2'b10, 1'b0, "wr_strberr");
      rd_txn(8'h80, 2'd0, 2'b11, 1'b0, 1'b0, "rd_decerr");
      rd_txn(8'h04, 2'd0, 2'b00, 1'b1, 1'b1, "rd_after_strberr");
   endtask

   task automatic test_arbitration;
      exp_t e;
      int rise;
      @(negedge clk);
      srst = 1'b1;
      @(posedge clk);
      #1 srst = 1'b0;
      viol = 2'd0;
      order.delete();
      e.resp = 2'b00; e.data = '0;
      bq.push_back(e);
      exp_mem[3] = 32'h12345678;
      e.data = 32'h12345678;
      rq.push_back(e);
      @(negedge clk);
      bus.wdata = 32'h12345678; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
      @(posedge clk);
      #1 bus.wvalid = 1'b0;
      repeat (3) @(negedge clk);
      bus.awaddr = 8'h0C; bus.awvalid = 1'b1;
      bus.araddr = 8'h0C; bus.arvalid = 1'b1;
      @(posedge clk);
      #1 bus.awvalid = 1'b0; bus.arvalid = 1'b0;
      @(negedge clk);
      wait_b("arb_b", 5);
      wait_r("arb_r", 5, rise);
      checks++;
      if (order.size() != 2 || order[0] != 1 || order[1] != 0) begin
         errors++;
         $display("FAIL arb_order: got %0d strobes first=%0d want write(1) then read(0)",
                  order.size(), order.size() > 0 ? order[0] : -1);
      end
   endtask

   task automatic test_reset_mid;
      int n = 0;
      bit seen = 1'b0;
      viol = 2'd0;
      @(negedge clk);
      bus.wdata = 32'h55555555; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
      bus.araddr = 8'h08; bus.arvalid = 1'b1;
      @(posedge clk);
      #1 bus.wvalid = 1'b0; bus.arvalid = 1'b0;
      @(negedge clk);
      while (reg_read !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (reg_read !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_exec: reg_read got=%b want=1", reg_read);
      end
      srst = 1'b1;
      @(posedge clk);
      #1 srst = 1'b0;
      @(negedge clk);
      checks++;
      if ({reg_read, bus.awready, bus.wready, bus.arready} !== 4'b0111) begin
         errors++;
         $display("FAIL rst_mid_state: reg_read,awready,wready,arready got=%b want=0111",
                  {reg_read, bus.awready, bus.wready, bus.arready});
      end
      repeat (10) begin
         if (bus.rvalid === 1'b1 || bus.bvalid === 1'b1) seen = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL rst_mid_noresp: response seen got=1 want=0");
      end
      rd_txn(8'h08, 2'd0, 2'b00, 1'b1, 1'b1, "rd_after_rst");
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         mem[i] = 32'hA500_0000 | i;
         exp_mem[i] = 32'hA500_0000 | i;
      end
      bus.awaddr = '0; bus.awvalid = 1'b0;
      bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
      bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
      test_reset;
      test_write;
      test_read;
      test_violations;
      test_precheck;
      test_arbitration;
      test_reset_mid;
      checks++;
      if (both_cnt !== 0) begin
         errors++;
         $display("FAIL strobe_exclusive: both strobes high in %0d cycles want 0", both_cnt);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
